// File: rtl/edit_mem_buf_alloc_arb_pkg.sv
// ============================================================================
// Module      : edit_mem_buf_alloc_arb_pkg
// Description : Shared widths, defaults and helpers for the edit-memory allocator.
// Revision    : 1.0
// ============================================================================
`default_nettype none

`ifndef EM_BUF_PTR_NBITS
`define EM_BUF_PTR_NBITS 8
`endif
`ifndef EM_PU_NUM
`define EM_PU_NUM 4
`endif
`ifndef EM_PU_ID_NBITS
`define EM_PU_ID_NBITS 2
`endif

package edit_mem_buf_alloc_arb_pkg;

    localparam int TAG_FIFO_DEPTH     = 4;
    localparam int TAG_FIFO_PTR_NBITS = 2;
    localparam int STATS_CNT_NBITS    = 16;

    typedef logic [STATS_CNT_NBITS-1:0] stat_cnt_t;

    function automatic stat_cnt_t sat_inc(input stat_cnt_t value);
        return (value == '1) ? value : value + 1'b1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/edit_mem_alloc_tag_fifo.sv
// ============================================================================
// Module      : edit_mem_alloc_tag_fifo
// Description : Flop-based in-order FIFO holding the PU id of each issued request.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module edit_mem_alloc_tag_fifo
    import edit_mem_buf_alloc_arb_pkg::*;
#(
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             empty,
    output logic             full
);

    logic [WIDTH-1:0]              mem [TAG_FIFO_DEPTH];
    logic [TAG_FIFO_PTR_NBITS-1:0] wr_ptr;
    logic [TAG_FIFO_PTR_NBITS-1:0] rd_ptr;
    logic [TAG_FIFO_PTR_NBITS:0]   count;
    logic                          do_push;
    logic                          do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign empty   = (count == '0);
    assign full    = (count == (TAG_FIFO_PTR_NBITS+1)'(TAG_FIFO_DEPTH));
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            // simultaneous push and pop leaves the occupancy unchanged
            if (do_push && !do_pop)      count <= count + 1'b1;
            else if (!do_push && do_pop) count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

`default_nettype wire

// File: rtl/edit_mem_buf_alloc_arb.sv
// ============================================================================
// Module      : edit_mem_buf_alloc_arb
// Description : Round-robin multi-PU buffer allocator in front of the free-buffer
//               controller. Optional counters: EM_BUF_ALLOC_STATS_EN.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module edit_mem_buf_alloc_arb
    import edit_mem_buf_alloc_arb_pkg::*;
#(
    parameter int NUM_PU      = `EM_PU_NUM,
    parameter int PU_ID_NBITS = `EM_PU_ID_NBITS,
    parameter int BPTR_NBITS  = `EM_BUF_PTR_NBITS
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   freeb_init_done,
    input  logic [NUM_PU-1:0]      alloc_req,
    output logic                   alloc_valid,
    output logic [PU_ID_NBITS-1:0] alloc_id,
    output logic [BPTR_NBITS-1:0]  alloc_ptr,
    output logic [NUM_PU-1:0]      alloc_pending,
`ifdef EM_BUF_ALLOC_STATS_EN
    output logic [15:0]            alloc_grant_cnt,
    output logic [15:0]            alloc_retry_cnt,
`endif
    output logic                   pu_buf_req,
    input  logic                   pu_buf_valid,
    input  logic                   pu_buf_available,
    input  logic [BPTR_NBITS-1:0]  pu_buf_ptr,
    output logic                   tag_err
);

    logic [NUM_PU-1:0]      pend;
    logic [NUM_PU-1:0]      infl;
    logic [NUM_PU-1:0]      eligible;
    logic [NUM_PU-1:0]      pop_mask;
    logic [NUM_PU-1:0]      succ_mask;
    logic [NUM_PU-1:0]      grant_mask;
    logic [PU_ID_NBITS-1:0] rr_ptr;
    logic [PU_ID_NBITS-1:0] grant_id;
    logic [PU_ID_NBITS-1:0] tag_head;
    logic                   grant_vld;
    logic                   fifo_empty;
    logic                   fifo_full;
    logic                   issue;
    logic                   pop;

    assign pop   = pu_buf_valid && !fifo_empty;
    assign issue = grant_vld && freeb_init_done && !fifo_full;

    for (genvar i = 0; i < NUM_PU; i++) begin : g_pu
        assign pop_mask[i]   = pop && (tag_head == PU_ID_NBITS'(i));
        assign succ_mask[i]  = pop_mask[i] && pu_buf_available;
        assign grant_mask[i] = issue && (grant_id == PU_ID_NBITS'(i));
    end

    // A PU whose empty response is consumed this cycle may be re-issued at once.
    assign eligible = pend & ~succ_mask & ~(infl & ~pop_mask);

    // First pass picks the lowest eligible PU; second overrides with the lowest at or after rr_ptr.
    always_comb begin
        grant_vld = 1'b0;
        grant_id  = '0;
        for (int i = NUM_PU-1; i >= 0; i--) begin
            if (eligible[i]) begin
                grant_vld = 1'b1;
                grant_id  = PU_ID_NBITS'(i);
            end
        end
        for (int i = NUM_PU-1; i >= 0; i--) begin
            if (eligible[i] && (PU_ID_NBITS'(i) >= rr_ptr)) grant_id = PU_ID_NBITS'(i);
        end
    end

    edit_mem_alloc_tag_fifo #(
        .WIDTH (PU_ID_NBITS)
    ) u_tag_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (issue),
        .push_data (grant_id),
        .pop       (pop),
        .rd_data   (tag_head),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend        <= '0;
            infl        <= '0;
            rr_ptr      <= '0;
            pu_buf_req  <= 1'b0;
            alloc_valid <= 1'b0;
            alloc_id    <= '0;
            alloc_ptr   <= '0;
            tag_err     <= 1'b0;
        end else begin
            pend       <= (pend | alloc_req) & ~succ_mask;
            infl       <= (infl & ~pop_mask) | grant_mask;
            pu_buf_req <= issue;
            if (issue) begin
                rr_ptr <= (grant_id == PU_ID_NBITS'(NUM_PU-1)) ? '0 : grant_id + 1'b1;
            end
            alloc_valid <= pop && pu_buf_available;
            if (pop && pu_buf_available) begin
                alloc_id  <= tag_head;
                alloc_ptr <= pu_buf_ptr;
            end
            if (pu_buf_valid && fifo_empty) tag_err <= 1'b1;
        end
    end

    assign alloc_pending = pend;

`ifdef EM_BUF_ALLOC_STATS_EN
    stat_cnt_t grant_cnt;
    stat_cnt_t retry_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_cnt <= '0;
            retry_cnt <= '0;
        end else begin
            if (pop && pu_buf_available)  grant_cnt <= sat_inc(grant_cnt);
            if (pop && !pu_buf_available) retry_cnt <= sat_inc(retry_cnt);
        end
    end

    assign alloc_grant_cnt = grant_cnt;
    assign alloc_retry_cnt = retry_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_edit_mem_buf_alloc_arb.sv
// ============================================================================
// Module      : tb_edit_mem_buf_alloc_arb
// Description : Directed self-checking bench with a fixed-latency responder model.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_edit_mem_buf_alloc_arb;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       freeb_init_done = 1'b1;
    logic [3:0] alloc_req = '0;
    logic       alloc_valid;
    logic [1:0] alloc_id;
    logic [7:0] alloc_ptr;
    logic [3:0] alloc_pending;
    logic       pu_buf_req;
    logic       pu_buf_valid;
    logic       pu_buf_available;
    logic [7:0] pu_buf_ptr;
    logic       tag_err;
`ifdef EM_BUF_ALLOC_STATS_EN
    logic [15:0] alloc_grant_cnt;
    logic [15:0] alloc_retry_cnt;
`endif

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    edit_mem_buf_alloc_arb #(
        .NUM_PU      (4),
        .PU_ID_NBITS (2),
        .BPTR_NBITS  (8)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .freeb_init_done  (freeb_init_done),
        .alloc_req        (alloc_req),
        .alloc_valid      (alloc_valid),
        .alloc_id         (alloc_id),
        .alloc_ptr        (alloc_ptr),
        .alloc_pending    (alloc_pending),
`ifdef EM_BUF_ALLOC_STATS_EN
        .alloc_grant_cnt  (alloc_grant_cnt),
        .alloc_retry_cnt  (alloc_retry_cnt),
`endif
        .pu_buf_req       (pu_buf_req),
        .pu_buf_valid     (pu_buf_valid),
        .pu_buf_available (pu_buf_available),
        .pu_buf_ptr       (pu_buf_ptr),
        .tag_err          (tag_err)
    );

    // Free-buffer controller model: answers each request exactly 3 cycles later.
    logic [2:0] req_d;
    logic [8:0] rsp_q [$];
    logic       rsp_avail;
    logic [7:0] rsp_ptr;
    logic       spur = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_d     <= '0;
            rsp_avail <= 1'b0;
            rsp_ptr   <= '0;
        end else begin
            req_d <= {req_d[1:0], pu_buf_req};
            if (req_d[1]) begin
                if (rsp_q.size() > 0) begin
                    rsp_avail <= rsp_q[0][8];
                    rsp_ptr   <= rsp_q[0][7:0];
                    rsp_q.delete(0);
                end else begin
                    rsp_avail <= 1'b0;
                    rsp_ptr   <= '0;
                end
            end
        end
    end

    assign pu_buf_valid     = req_d[2] | spur;
    assign pu_buf_available = spur ? 1'b0 : rsp_avail;
    assign pu_buf_ptr       = rsp_ptr;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        alloc_req = '0;
        spur = 1'b0;
        freeb_init_done = 1'b1;
        rsp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (alloc_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %0b want 0", alloc_valid); end
        total++; if (pu_buf_req !== 1'b0) begin bad++; $display("FAIL reset_req: got %0b want 0", pu_buf_req); end
        total++; if (alloc_pending !== 4'b0000) begin bad++; $display("FAIL reset_pending: got %b want 0000", alloc_pending); end
        total++; if (tag_err !== 1'b0) begin bad++; $display("FAIL reset_tag_err: got %0b want 0", tag_err); end
        total++; if ({alloc_id, alloc_ptr} !== 10'd0) begin bad++; $display("FAIL reset_id_ptr: got %0h want 0", {alloc_id, alloc_ptr}); end
    endtask

    task automatic test_single();
        do_reset();
        rsp_q.push_back({1'b1, 8'h1A});
        alloc_req = 4'b0100;
        tick();                                   // cycle 1
        alloc_req = '0;
        total++; if (alloc_pending !== 4'b0100) begin bad++; $display("FAIL single_pending: got %b want 0100", alloc_pending); end
        total++; if (pu_buf_req !== 1'b0) begin bad++; $display("FAIL single_req_c1: got %0b want 0", pu_buf_req); end
        tick();                                   // cycle 2
        total++; if (pu_buf_req !== 1'b1) begin bad++; $display("FAIL single_req_c2: got %0b want 1", pu_buf_req); end
        repeat (3) tick();                        // cycle 5
        total++; if (alloc_valid !== 1'b0) begin bad++; $display("FAIL single_valid_c5: got %0b want 0", alloc_valid); end
        tick();                                   // cycle 6
        total++; if (alloc_valid !== 1'b1 || alloc_id !== 2'd2 || alloc_ptr !== 8'h1A) begin
            bad++; $display("FAIL single_return: got v=%0b id=%0d ptr=%0h want v=1 id=2 ptr=1a", alloc_valid, alloc_id, alloc_ptr);
        end
        tick();                                   // cycle 7
        total++; if (alloc_valid !== 1'b0 || alloc_pending !== 4'b0000) begin
            bad++; $display("FAIL single_after: got v=%0b pend=%b want v=0 pend=0000", alloc_valid, alloc_pending);
        end
    endtask

    task automatic test_all_pus();
        do_reset();
        for (int p = 5; p <= 8; p++) rsp_q.push_back({1'b1, 8'(p)});
        alloc_req = 4'b1111;
        tick();                                   // cycle 1
        alloc_req = '0;
        total++; if (alloc_pending !== 4'b1111) begin bad++; $display("FAIL all_pending: got %b want 1111", alloc_pending); end
        for (int c = 2; c <= 9; c++) begin
            tick();
            if (c <= 5) begin
                total++; if (pu_buf_req !== 1'b1) begin bad++; $display("FAIL all_req_c%0d: got %0b want 1", c, pu_buf_req); end
            end else begin
                total++; if (pu_buf_req !== 1'b0) begin bad++; $display("FAIL all_noreq_c%0d: got %0b want 0", c, pu_buf_req); end
                total++; if (alloc_valid !== 1'b1 || alloc_id !== 2'(c-6) || alloc_ptr !== 8'(c-1)) begin
                    bad++; $display("FAIL all_ret_c%0d: got v=%0b id=%0d ptr=%0d want v=1 id=%0d ptr=%0d",
                                    c, alloc_valid, alloc_id, alloc_ptr, c-6, c-1);
                end
            end
        end
        tick();
        total++; if (alloc_pending !== 4'b0000) begin bad++; $display("FAIL all_drain: got %b want 0000", alloc_pending); end
`ifdef EM_BUF_ALLOC_STATS_EN
        total++; if (alloc_grant_cnt !== 16'd4) begin bad++; $display("FAIL all_grant_cnt: got %0d want 4", alloc_grant_cnt); end
`endif
    endtask

    task automatic test_empty_pool();
        do_reset();
        rsp_q.push_back({1'b0, 8'h00});
        rsp_q.push_back({1'b1, 8'h03});
        alloc_req = 4'b0010;
        tick();
        alloc_req = '0;
        tick();                                   // cycle 2
        total++; if (pu_buf_req !== 1'b1) begin bad++; $display("FAIL empty_req_c2: got %0b want 1", pu_buf_req); end
        repeat (4) tick();                        // cycle 6, empty response was in cycle 5
        total++; if (alloc_valid !== 1'b0) begin bad++; $display("FAIL empty_no_valid: got %0b want 0", alloc_valid); end
        total++; if (pu_buf_req !== 1'b1) begin bad++; $display("FAIL empty_reissue: got %0b want 1", pu_buf_req); end
        total++; if (alloc_pending !== 4'b0010) begin bad++; $display("FAIL empty_pending: got %b want 0010", alloc_pending); end
`ifdef EM_BUF_ALLOC_STATS_EN
        total++; if (alloc_retry_cnt !== 16'd1) begin bad++; $display("FAIL empty_retry_cnt: got %0d want 1", alloc_retry_cnt); end
`endif
        repeat (4) tick();                        // cycle 10
        total++; if (alloc_valid !== 1'b1 || alloc_id !== 2'd1 || alloc_ptr !== 8'h03) begin
            bad++; $display("FAIL empty_retry_ret: got v=%0b id=%0d ptr=%0h want v=1 id=1 ptr=3", alloc_valid, alloc_id, alloc_ptr);
        end
    endtask

    task automatic test_duplicate();
        int reqs = 0;
        int rets = 0;
        do_reset();
        rsp_q.push_back({1'b1, 8'h44});
        for (int c = 0; c <= 12; c++) begin
            alloc_req = (c == 0 || c == 3) ? 4'b0001 : 4'b0000;
            if (pu_buf_req === 1'b1) reqs++;
            if (alloc_valid === 1'b1 && alloc_id === 2'd0 && alloc_ptr === 8'h44) rets++;
            tick();
        end
        alloc_req = '0;
        total++; if (reqs !== 1) begin bad++; $display("FAIL dup_reqs: got %0d want 1", reqs); end
        total++; if (rets !== 1) begin bad++; $display("FAIL dup_returns: got %0d want 1", rets); end
        total++; if (alloc_pending !== 4'b0000) begin bad++; $display("FAIL dup_pending: got %b want 0000", alloc_pending); end
    endtask

    task automatic test_init_gate();
        int reqs = 0;
        do_reset();
        freeb_init_done = 1'b0;
        rsp_q.push_back({1'b1, 8'h77});
        alloc_req = 4'b1000;
        tick();
        alloc_req = '0;
        for (int c = 0; c < 5; c++) begin
            if (pu_buf_req === 1'b1) reqs++;
            tick();
        end
        total++; if (reqs !== 0) begin bad++; $display("FAIL gate_blocked: got %0d reqs want 0", reqs); end
        total++; if (alloc_pending !== 4'b1000) begin bad++; $display("FAIL gate_pending: got %b want 1000", alloc_pending); end
        freeb_init_done = 1'b1;
        total++; if (pu_buf_req !== 1'b0) begin bad++; $display("FAIL gate_raise_c0: got %0b want 0", pu_buf_req); end
        tick();
        total++; if (pu_buf_req !== 1'b1) begin bad++; $display("FAIL gate_raise_c1: got %0b want 1", pu_buf_req); end
        repeat (4) tick();
        total++; if (alloc_valid !== 1'b1 || alloc_id !== 2'd3 || alloc_ptr !== 8'h77) begin
            bad++; $display("FAIL gate_return: got v=%0b id=%0d ptr=%0h want v=1 id=3 ptr=77", alloc_valid, alloc_id, alloc_ptr);
        end
    endtask

    task automatic test_spurious();
        do_reset();
        spur = 1'b1;
        tick();
        spur = 1'b0;
        total++; if (tag_err !== 1'b1) begin bad++; $display("FAIL spur_tag_err: got %0b want 1", tag_err); end
        total++; if (alloc_valid !== 1'b0) begin bad++; $display("FAIL spur_no_valid: got %0b want 0", alloc_valid); end
        repeat (3) tick();
        total++; if (tag_err !== 1'b1) begin bad++; $display("FAIL spur_sticky: got %0b want 1", tag_err); end
        total++; if (pu_buf_req !== 1'b0 || alloc_pending !== 4'b0000) begin
            bad++; $display("FAIL spur_state: got req=%0b pend=%b want req=0 pend=0000", pu_buf_req, alloc_pending);
        end
`ifdef EM_BUF_ALLOC_STATS_EN
        total++; if (alloc_retry_cnt !== 16'd0) begin bad++; $display("FAIL spur_retry_cnt: got %0d want 0", alloc_retry_cnt); end
`endif
        do_reset();
        total++; if (tag_err !== 1'b0) begin bad++; $display("FAIL spur_cleared: got %0b want 0", tag_err); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_all_pus();
        test_empty_pool();
        test_duplicate();
        test_init_gate();
        test_spurious();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
